// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared types, PC-1 table and shift helpers for the DES key schedule
package des_pkg;

    typedef logic [28:1] half_t;
    typedef logic [48:1] subkey_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Bit r-1 set means round r rotates by one position, clear means two.
    localparam logic [15:0] DES_SHIFTS = 16'h8103;

    // PC1_TABLE[i] names the key bit that lands in PC-1 output bit i+1.
    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    function automatic int total_shift(logic [15:0] sched, int rounds);
        int t = 0;
        for (int i = 0; i < rounds; i++) begin
            t += sched[4'(i)] ? 1 : 2;
        end
        return t;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - PC-2 permutation, 56-bit C/D state to 48-bit round subkey
module des_pc2 (
    input  logic [56:1] cd,
    output logic [48:1] k
);

    localparam int PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    for (genvar i = 0; i < 48; i++) begin : g_pc2
        assign k[i+1] = cd[6'(PC2_TABLE[i])];
    end

    logic unused_cd;
    assign unused_cd = ^{cd[9], cd[18], cd[22], cd[25], cd[35], cd[38], cd[43], cd[54]};

endmodule

// File: rtl/key_pc1.sv
// rtl/key_pc1.sv - PC-1 permutation, 64-bit key with parity to 56-bit C/D seed
module key_pc1
    import des_pkg::*;
(
    input  logic [64:1] key,
    output logic [56:1] pc1
);

    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign pc1[i+1] = key[7'(PC1_TABLE[i])];
    end

    // Parity bits never reach the schedule.
    logic unused_parity;
    assign unused_parity = ^{key[8], key[16], key[24], key[32],
                             key[40], key[48], key[56], key[64]};

endmodule

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - sequential DES subkey generator, one PC-2 subkey per handshake
module des_key_schedule
    import des_pkg::*;
#(
    parameter int          ROUNDS         = 16,
    parameter logic [15:0] SHIFT_SCHEDULE = DES_SHIFTS,
    parameter int          ROUND_W        = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               decrypt,
    input  logic [64:1]        key,
    output logic               busy,
    output logic               subkey_valid,
    input  logic               subkey_ready,
    output subkey_t            subkey,
    output logic [ROUND_W-1:0] round_idx,
    output logic               done
);

    localparam logic [ROUND_W-1:0] FIRST_R     = ROUND_W'(1);
    localparam logic [ROUND_W-1:0] LAST_R      = ROUND_W'(ROUNDS);
    localparam int                 TOTAL_SHIFT = total_shift(SHIFT_SCHEDULE, ROUNDS);

    state_t              state;
    logic                mode;
    logic [ROUND_W-1:0]  r;
    half_t               c, d;
    logic [56:1]         seed;
    half_t               c0, d0;
    logic                hs, last;

    function automatic logic one_step(logic [ROUND_W-1:0] rr);
        return SHIFT_SCHEDULE[4'(rr - FIRST_R)];
    endfunction

    // DES bit 1 sits at index 1, so a DES left rotation moves bits toward index 1.
    function automatic half_t rotl(half_t h, logic one);
        return one ? {h[1], h[28:2]} : {h[2:1], h[28:3]};
    endfunction

    function automatic half_t rotr(half_t h, logic one);
        return one ? {h[27:1], h[28]} : {h[26:1], h[28:27]};
    endfunction

    key_pc1 u_pc1 (
        .key (key),
        .pc1 (seed)
    );

    assign c0 = seed[28:1];
    assign d0 = seed[56:29];

    // C holds DES bits 1..28 of the PC-2 input, so it occupies the low indices.
    des_pc2 u_pc2 (
        .cd ({d, c}),
        .k  (subkey)
    );

    assign round_idx = r;
    assign hs        = subkey_valid & subkey_ready;
    assign last      = mode ? (r == FIRST_R) : (r == LAST_R);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mode         <= 1'b0;
            r            <= '0;
            c            <= '0;
            d            <= '0;
            busy         <= 1'b0;
            subkey_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode         <= decrypt;
                        busy         <= 1'b1;
                        subkey_valid <= 1'b1;
                        state        <= RUN;
                        if (decrypt) begin
                            // A full 28-position schedule returns C16/D16 to C0/D0.
                            c <= c0;
                            d <= d0;
                            r <= LAST_R;
                        end else begin
                            c <= rotl(c0, one_step(FIRST_R));
                            d <= rotl(d0, one_step(FIRST_R));
                            r <= FIRST_R;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (last) begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            subkey_valid <= 1'b0;
                            done         <= 1'b1;
                        end else if (mode) begin
                            c <= rotr(c, one_step(r));
                            d <= rotr(d, one_step(r));
                            r <= r - FIRST_R;
                        end else begin
                            c <= rotl(c, one_step(r + FIRST_R));
                            d <= rotl(d, one_step(r + FIRST_R));
                            r <= r + FIRST_R;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Reverse order only undoes the rotations when they add up to one full turn.
    always @(posedge clk) begin
        if (rst_n && state == IDLE && start && decrypt) begin
            assert (TOTAL_SHIFT == 28);
        end
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - self-checking bench for des_key_schedule
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic        subkey_ready = 1'b0;
    logic [64:1] key = '0;
    logic        busy, subkey_valid, done;
    logic [48:1] subkey;
    logic [4:0]  round_idx;
    logic [47:0] sk_hex;

    always #5 clk = ~clk;

    des_key_schedule dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .decrypt      (decrypt),
        .key          (key),
        .busy         (busy),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .round_idx    (round_idx),
        .done         (done)
    );

    // Hex constants are written with DES bit 1 leftmost.
    assign sk_hex = {<<{subkey}};

    localparam int PC1_M [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_M [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam logic [15:0] SCHED  = 16'h8103;
    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PARITY = 64'h0101010101010101;
    localparam logic [47:0] K1_A   = 48'h1B02EFFC7072;
    localparam logic [47:0] K2_A   = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16_A  = 48'hCB3D8B0E17F5;

    int total = 0;
    int bad = 0;
    int hs_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Subkey r straight from the definition: cumulative rotation of C0/D0, then PC-2.
    function automatic logic [47:0] model_key(logic [63:0] kh, int rnd);
        logic [55:0] cd0, cdr;
        logic [47:0] k;
        int tot, src;
        tot = 0;
        for (int i = 0; i < 56; i++) cd0[6'(55 - i)] = kh[6'(64 - PC1_M[6'(i)])];
        for (int q = 0; q < rnd; q++) tot += SCHED[4'(q)] ? 1 : 2;
        for (int j = 0; j < 56; j++) begin
            src = (j < 28) ? (j + tot) % 28 : 28 + (j - 28 + tot) % 28;
            cdr[6'(55 - j)] = cd0[6'(55 - src)];
        end
        for (int i = 0; i < 48; i++) k[6'(47 - i)] = cdr[6'(56 - PC2_M[6'(i)])];
        return k;
    endfunction

    typedef struct packed {
        logic [4:0]  idx;
        logic [47:0] k;
    } exp_t;
    typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;

    exp_t    expq[$];
    mstate_t ms = M_IDLE;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outs", 64'({busy, subkey_valid, done, round_idx}), 64'(0));
            check("reset_subkey", 64'(sk_hex), 64'(0));
            expq.delete();
            ms = M_IDLE;
        end else begin
            case (ms)
                M_IDLE: begin
                    check("idle_flags", 64'({busy, subkey_valid, done}), 64'(0));
                    if (start) begin
                        for (int i = 1; i <= 16; i++) begin
                            expq.push_back({5'(decrypt ? 17 - i : i),
                                            model_key({<<{key}}, decrypt ? 17 - i : i)});
                        end
                        ms = M_RUN;
                    end
                end
                M_RUN: begin
                    check("run_flags", 64'({busy, subkey_valid, done}), 64'(3'b110));
                    if (expq.size() > 0) begin
                        check("round_idx", 64'(round_idx), 64'(expq[0].idx));
                        check("subkey", 64'(sk_hex), 64'(expq[0].k));
                    end
                    if (subkey_valid && subkey_ready) begin
                        hs_count++;
                        if (expq.size() > 0) void'(expq.pop_front());
                        if (expq.size() == 0) ms = M_DONE;
                    end
                end
                M_DONE: begin
                    check("done_pulse", 64'({busy, subkey_valid, done}), 64'(3'b001));
                    ms = M_IDLE;
                end
                default: ms = M_IDLE;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [63:0] kh, input logic dec);
        key     = {<<{kh}};
        decrypt = dec;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(done), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;

        check("model_k1", 64'(model_key(KEY_A, 1)), 64'(K1_A));
        check("model_k2", 64'(model_key(KEY_A, 2)), 64'(K2_A));
        check("model_k16", 64'(model_key(KEY_A, 16)), 64'(K16_A));
        check("model_parity", 64'(model_key(KEY_A ^ PARITY, 16)), 64'(K16_A));

        repeat (2) tick();
        check("rst_state", 64'({busy, subkey_valid, done, round_idx}), 64'(0));
        check("rst_subkey", 64'(sk_hex), 64'(0));
        rst_n = 1'b1;
        tick();

        // Encrypt with ready held high.
        subkey_ready = 1'b1;
        hs_count = 0;
        launch(KEY_A, 1'b0);
        @(negedge clk);
        check("s1_k1", 64'(sk_hex), 64'(K1_A));
        check("s1_idx1", 64'(round_idx), 64'(1));
        @(negedge clk);
        check("s1_k2", 64'(sk_hex), 64'(K2_A));
        check("s1_idx2", 64'(round_idx), 64'(2));
        repeat (14) @(negedge clk);
        check("s1_k16", 64'(sk_hex), 64'(K16_A));
        check("s1_idx16", 64'(round_idx), 64'(16));
        @(negedge clk);
        check("s1_done", 64'(done), 64'(1));
        check("s1_hs", 64'(hs_count), 64'(16));
        tick();

        // Decrypt order.
        launch(KEY_A, 1'b1);
        @(negedge clk);
        check("s2_first", 64'(sk_hex), 64'(K16_A));
        check("s2_idx16", 64'(round_idx), 64'(16));
        repeat (15) @(negedge clk);
        check("s2_last", 64'(sk_hex), 64'(K1_A));
        check("s2_idx1", 64'(round_idx), 64'(1));
        wait_done("s2_done");
        tick();

        // Random backpressure at roughly 30% ready.
        subkey_ready = 1'b0;
        hs_count = 0;
        launch(KEY_A, 1'b0);
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            subkey_ready = ($urandom_range(0, 9) < 3);
            tick();
            n++;
        end
        check("s3_done", 64'(done), 64'(1));
        check("s3_hs", 64'(hs_count), 64'(16));
        subkey_ready = 1'b1;
        tick();

        // Start held through RUN and DONE is ignored, then taken in the following idle cycle.
        hs_count = 0;
        launch(KEY_A, 1'b0);
        repeat (3) tick();
        key     = {<<{KEY_B}};
        decrypt = 1'b1;
        start   = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("s4_done_a", 64'(done), 64'(1));
        tick();
        tick();
        start = 1'b0;
        @(negedge clk);
        check("s4_b_first", 64'(sk_hex), 64'(model_key(KEY_B, 16)));
        check("s4_b_idx", 64'(round_idx), 64'(16));
        wait_done("s4_done_b");
        check("s4_hs", 64'(hs_count), 64'(32));
        tick();

        // Asynchronous reset at round 7.
        decrypt = 1'b0;
        launch(KEY_A, 1'b0);
        n = 0;
        while (round_idx != 5'd7 && n < 50) begin
            tick();
            n++;
        end
        check("s5_reached7", 64'(round_idx), 64'(7));
        rst_n = 1'b0;
        #1;
        check("s5_async_flags", 64'({busy, subkey_valid, done, round_idx}), 64'(0));
        check("s5_async_subkey", 64'(sk_hex), 64'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("s5_no_done", 64'(done), 64'(0));
        launch(KEY_A, 1'b0);
        @(negedge clk);
        check("s5_k1", 64'(sk_hex), 64'(K1_A));
        wait_done("s5_done");
        tick();

        // Parity bits must not matter.
        launch(KEY_A ^ PARITY, 1'b0);
        @(negedge clk);
        check("s6_k1", 64'(sk_hex), 64'(K1_A));
        wait_done("s6_done");
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
